// File: rtl/pipeline_2.sv
// ============================================================================
// pipeline_2
// ----------------------------------------------------------------------------
// Two-stage registered datapath leaf. The four operand bits are captured in an
// input register stage, two fixed Boolean functions are evaluated from those
// flops, and the results are held in an output register stage. X and Y come
// straight from flops, so they are glitch-free and never depend
// combinationally on the inputs.
//
// The block has no handshake: there is no valid/ready pair and no stall. A new
// operand vector is accepted on every rising edge. The result for that vector
// appears one edge later, so it passes two register stages.
//
// Ports
//   clk    in   rising-edge clock for all flops
//   reset  in   asynchronous, active-high; clears all six flops at once
//   A..D   in   operand bits
//   X      out  registered (A & B) ^ (C | D)
//   Y      out  registered ~((A | B) & (C ^ D))
// ============================================================================
module pipeline_2 (
    input  logic clk,
    input  logic reset,
    input  logic A,
    input  logic B,
    input  logic C,
    input  logic D,
    output logic X,
    output logic Y
);

    // Stage 1: input register
    logic s1_a_q, s1_b_q, s1_c_q, s1_d_q;
    // Stage 2: output register
    logic x_q, y_q;
    logic x_d, y_d;

    // Both functions read only the stage-1 flops, never the raw inputs.
    always_comb begin
        x_d = (s1_a_q & s1_b_q) ^ (s1_c_q | s1_d_q);
        y_d = ~((s1_a_q | s1_b_q) & (s1_c_q ^ s1_d_q));
    end

    // Reset clears every flop, including stage 2. Y therefore reads 0 while
    // reset is held, even though f(0000) gives Y=1. The value f(0000) only
    // appears after the first edge that follows the release of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_a_q <= 1'b0;
            s1_b_q <= 1'b0;
            s1_c_q <= 1'b0;
            s1_d_q <= 1'b0;
            x_q    <= 1'b0;
            y_q    <= 1'b0;
        end else begin
            s1_a_q <= A;
            s1_b_q <= B;
            s1_c_q <= C;
            s1_d_q <= D;
            x_q    <= x_d;
            y_q    <= y_d;
        end
    end

    assign X = x_q;
    assign Y = y_q;

endmodule

// File: tb/tb_pipeline_2.sv
// Testbench for pipeline_2.
// Inputs are driven from tasks. Outputs are sampled 1 ns after a rising edge,
// or in the middle of a cycle.
// The reference model computes each result by counting operand bits. A
// scoreboard queue delays each expected result by one edge, which matches the
// two-stage latency.
module tb_pipeline_2;

  logic clk;
  logic clk_en;
  logic reset;
  logic a, b, c, d;
  logic x, y;

  int checks;
  int errors;

  // Expected {X,Y} for each edge that is still to come.
  logic [1:0] exp_q[$];
  logic [1:0] last_exp;

  typedef struct {
    logic [3:0] v;    // {A,B,C,D}
    logic [1:0] exp;  // {X,Y}
  } vec_t;

  vec_t single_tab[4];
  vec_t stream_tab[4];

  pipeline_2 dut (
    .clk   (clk),
    .reset (reset),
    .A     (a),
    .B     (b),
    .C     (c),
    .D     (d),
    .X     (x),
    .Y     (y)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  // ---------------- reference model ----------------
  // X: "both of A,B" differs from "any of C,D".
  // Y: not ("at least one of A,B" and "exactly one of C,D").
  function automatic logic [1:0] ref_f(input logic [3:0] v);
    int ab, cd;
    logic rx, ry;
    ab = int'(v[3]) + int'(v[2]);
    cd = int'(v[1]) + int'(v[0]);
    rx = ((ab == 2) != (cd != 0));
    ry = !((ab >= 1) && (cd == 1));
    return {rx, ry};
  endfunction

  // After a reset, stage 1 holds 0000. The first edge therefore presents
  // f(0000).
  task automatic model_reset();
    exp_q.delete();
    exp_q.push_back(ref_f(4'b0000));
    last_exp = 2'b00;
  endtask

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [1:0] got, input logic [1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got XY=%b required XY=%b at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Present v, take one edge, then compare against the scoreboard.
  task automatic step(input logic [3:0] v);
    logic [1:0] e;
    {a, b, c, d} = v;
    exp_q.push_back(ref_f(v));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    last_exp = e;
    check("model", {x, y}, e);
  endtask

  // ---------------- test ----------------
  initial begin
    checks = 0;
    errors = 0;
    clk_en = 1'b0;
    reset = 1'b0;
    {a, b, c, d} = 4'b0000;

    single_tab[0] = '{4'b1111, 2'b01};
    single_tab[1] = '{4'b0101, 2'b10};
    single_tab[2] = '{4'b1100, 2'b11};
    single_tab[3] = '{4'b1011, 2'b11};
    stream_tab[0] = '{4'b1111, 2'b01};
    stream_tab[1] = '{4'b0101, 2'b10};
    stream_tab[2] = '{4'b1100, 2'b11};
    stream_tab[3] = '{4'b1011, 2'b11};

    // Reset with the clock stopped: the outputs must clear without any edge.
    #3;
    reset = 1'b1;
    #1;
    check("reset_async", {x, y}, 2'b00);
    model_reset();
    #2;
    reset = 1'b0;
    clk_en = 1'b1;
    step(4'b1111);
    check("reset_first_edge", {x, y}, 2'b01);

    // Hold each single vector across two edges.
    for (int i = 0; i < 4; i++) begin
      step(single_tab[i].v);
      step(single_tab[i].v);
      check($sformatf("single_%b", single_tab[i].v), {x, y}, single_tab[i].exp);
    end

    // Back-to-back streaming. The result of vector i shows after edge i+2.
    for (int i = 0; i < 5; i++) begin
      step((i < 4) ? stream_tab[i].v : 4'b0000);
      if (i >= 1)
        check($sformatf("stream_%0d", i + 1), {x, y}, stream_tab[i - 1].exp);
    end

    // Latency: inputs change between edges. The outputs may move only at an
    // edge.
    for (int i = 0; i < 6; i++) begin
      step(4'($urandom_range(0, 15)));
      for (int j = 0; j < 3; j++) begin
        {a, b, c, d} = 4'($urandom_range(0, 15));
        #2;
        check("hold_between_edges", {x, y}, last_exp);
      end
    end

    // Mid-stream reset while stage 1 holds 0101 (its result would be XY=10).
    step(4'b1111);
    step(4'b0101);
    #2;
    reset = 1'b1;
    #1;
    check("midstream_reset", {x, y}, 2'b00);
    model_reset();
    @(negedge clk);
    check("reset_held", {x, y}, 2'b00);
    reset = 1'b0;
    step(4'b0101);
    check("after_midstream_reset", {x, y}, 2'b01);

    // Exhaustive streaming sweep.
    for (int i = 0; i < 16; i++) step(4'(i));
    step(4'b0000);

    // Random streaming.
    for (int i = 0; i < 200; i++) step(4'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout required completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
